wb_fwd_tracker: RTL

//  Parametrised writeback tracker for the in-order pipeline. It holds one entry per post-ID stage
//  (stage 0 = EXE ... DEPTH-1 = WB) and commits the oldest entry to the register file.
//  It forwards the youngest in-flight result to RD_PORTS operand ports.
//  It detects late-result hazards (load-use) and inserts bubbles, so per-stage forwarding selects
//  are no longer hand-coded in the datapath.

---
 rtl/wb_fwd_tracker.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_fwd_tracker.sv
`default_nettype none
// ============================================================================
// Module      : wb_fwd_tracker
// Description : Writeback tracker for an in-order pipeline.
//
//               There is one entry per post-ID stage (stage 0 = EXE ...
//               stage DEPTH-1 = WB). The block:
//                 - commits the oldest entry to the register file,
//                 - forwards the youngest in-flight result to each operand
//                   port,
//                 - stalls ID on a late-result (load-use) hazard.
//
//               Optional statistics counters are compiled in when the macro
//               FWD_STAT_EN is defined.
// Ports       : clk, rst_n         clock, asynchronous active-low reset
//               hold_i, flush_i    external freeze, per-stage valid clear
//               issue_*            ID instruction fields and handshake
//               ex_result_i        ALU result for the stage-0 entry
//               late_data_i        memory data for the LATE_STAGE entry
//               rd_en_i, rd_addr_i, rf_data_i   operand requests, RF data
//               op_data_o, fwd_hit_o            forwarded operands
//               stall_o            late-result hazard
//               wb_en_o, wb_addr_o, wb_data_o   register-file write port
//               stat_stall_cnt_o, stat_fwd_cnt_o (FWD_STAT_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fwd_tracker #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 3,
    parameter int RD_PORTS   = 2,
    parameter int LATE_STAGE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         hold_i,
    input  logic [DEPTH-1:0]             flush_i,
    input  logic                         issue_valid_i,
    input  logic                         issue_wen_i,
    input  logic [ADDR_W-1:0]            issue_waddr_i,
    input  logic                         issue_late_i,
    output logic                         issue_ready_o,
    input  logic [DATA_W-1:0]            ex_result_i,
    input  logic [DATA_W-1:0]            late_data_i,
    input  logic [RD_PORTS-1:0]          rd_en_i,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr_i,
    input  logic [RD_PORTS*DATA_W-1:0]   rf_data_i,
    output logic [RD_PORTS*DATA_W-1:0]   op_data_o,
    output logic [RD_PORTS-1:0]          fwd_hit_o,
    output logic                         stall_o,
    output logic                         wb_en_o,
    output logic [ADDR_W-1:0]            wb_addr_o,
    output logic [DATA_W-1:0]            wb_data_o
`ifdef FWD_STAT_EN
    ,
    output logic [31:0]                  stat_stall_cnt_o,
    output logic [31:0]                  stat_fwd_cnt_o
`endif
);

    localparam int c_TOP = DEPTH - 1;

    // ------------------------------------------------------------------
    // Per-stage entry state
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  wen_q,   wen_d;
    logic [DEPTH-1:0]  late_q,  late_d;
    logic [ADDR_W-1:0] waddr_q [DEPTH];
    logic [ADDR_W-1:0] waddr_d [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];

    logic [DATA_W-1:0]   w_result [DEPTH];
    logic [DEPTH-1:0]    w_ready;
    logic [RD_PORTS-1:0] w_hit;
    logic [RD_PORTS-1:0] w_hazard;
    logic                w_stall;

    // ------------------------------------------------------------------
    // Result and readiness of each stage.
    //
    // A non-late stage-0 entry takes its value live from the ALU. A late
    // entry takes its value live from memory while it sits in LATE_STAGE.
    // Every other entry uses the value it captured when it advanced.
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 0 && !late_q[k]) begin
                w_result[k] = ex_result_i;
            end else if (k == LATE_STAGE && late_q[k]) begin
                w_result[k] = late_data_i;
            end else begin
                w_result[k] = data_q[k];
            end
            w_ready[k] = !late_q[k] || (k >= LATE_STAGE);
        end
    end

    // ------------------------------------------------------------------
    // Forwarding.
    //
    // The stages are scanned from oldest to youngest, so the last match,
    // which is the youngest, is the one that sticks. A port whose rd_en is
    // low still receives the forwarded value, but it never contributes to
    // a stall.
    // ------------------------------------------------------------------
    always_comb begin
        op_data_o = rf_data_i;
        w_hit     = '0;
        w_hazard  = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (valid_q[k] && wen_q[k]
                    && (waddr_q[k] == rd_addr_i[p*ADDR_W +: ADDR_W])
                    && (rd_addr_i[p*ADDR_W +: ADDR_W] != '0)) begin
                    w_hit[p]                        = 1'b1;
                    w_hazard[p]                     = !w_ready[k];
                    op_data_o[p*DATA_W +: DATA_W]   = w_result[k];
                end
            end
        end
    end

    assign fwd_hit_o     = w_hit;
    assign w_stall       = issue_valid_i && |(rd_en_i & w_hazard);
    assign stall_o       = w_stall;
    assign issue_ready_o = !hold_i && !w_stall;

    // ------------------------------------------------------------------
    // Commit from the oldest stage.
    // Writes to register 0 are dropped.
    // ------------------------------------------------------------------
    assign wb_en_o   = valid_q[c_TOP] && wen_q[c_TOP] && !hold_i
                       && (waddr_q[c_TOP] != '0);
    assign wb_addr_o = waddr_q[c_TOP];
    assign wb_data_o = w_result[c_TOP];

    // ------------------------------------------------------------------
    // Next state: advance or hold, then apply the flush mask.
    //
    // The flush mask is applied last, so it wins over whatever would have
    // moved into the flushed stage.
    // ------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        wen_d   = wen_q;
        late_d  = late_q;
        waddr_d = waddr_q;
        data_d  = data_q;
        if (!hold_i) begin
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                wen_d[k]   = wen_q[k-1];
                late_d[k]  = late_q[k-1];
                waddr_d[k] = waddr_q[k-1];
                data_d[k]  = w_result[k-1];
            end
            valid_d[0] = issue_valid_i && !w_stall;
            wen_d[0]   = issue_wen_i;
            late_d[0]  = issue_late_i;
            waddr_d[0] = issue_waddr_i;
            data_d[0]  = '0;
        end
        valid_d = valid_d & ~flush_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            wen_q   <= '0;
            late_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                waddr_q[k] <= '0;
                data_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            wen_q   <= wen_d;
            late_q  <= late_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
        end
    end

`ifdef FWD_STAT_EN
    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (w_stall && !hold_i && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (issue_ready_o && issue_valid_i && |(w_hit & rd_en_i)
                && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign stat_stall_cnt_o = stall_cnt_q;
    assign stat_fwd_cnt_o   = fwd_cnt_q;
`else
    // Statistics are not built: no counter state exists.
`endif

endmodule
`default_nettype wire
